// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the core memory port and the cache.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } lc3b_cache_state;

endpackage

// File: rtl/cache_control.sv
// Miss-handling FSM for lc3b_cache: victim choice, writeback and fill
// sequencing, and the hit-response strobe.
module cache_control
    import lc3b_types::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic            i_hit,
    input  logic [1:0]      i_valid,
    input  logic [1:0]      i_dirty,
    input  logic            i_lru,
    input  logic            i_pmem_resp,
    output lc3b_cache_state o_state,
    output logic            o_victim,
    output logic            o_start,
    output logic            o_hit_resp,
    output logic            o_wb_done,
    output logic            o_fill_done,
    output logic            o_pmem_read,
    output logic            o_pmem_write
);

    lc3b_cache_state r_state;
    lc3b_cache_state w_next;
    logic            r_victim;
    logic            w_pick;

    // an empty way always wins over the LRU choice
    assign w_pick   = !i_valid[0] ? 1'b0 : (!i_valid[1] ? 1'b1 : i_lru);
    assign o_state  = r_state;
    assign o_victim = r_victim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_victim <= 1'b0;
        end else begin
            r_state <= w_next;
            if (o_start)
                r_victim <= w_pick;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_req && !i_hit)
                    w_next = (i_valid[w_pick] && i_dirty[w_pick]) ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                if (i_pmem_resp)
                    w_next = FILL;
            end
            FILL: begin
                if (i_pmem_resp)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_start      = 1'b0;
        o_hit_resp   = 1'b0;
        o_wb_done    = 1'b0;
        o_fill_done  = 1'b0;
        o_pmem_read  = 1'b0;
        o_pmem_write = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_hit_resp = i_req && i_hit;
                o_start    = i_req && !i_hit;
            end
            WRITEBACK: begin
                o_pmem_write = 1'b1;
                o_wb_done    = i_pmem_resp;
            end
            FILL: begin
                o_pmem_read = 1'b1;
                o_fill_done = i_pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3b_cache.sv
// 2-way set-associative write-back, write-allocate cache between the
// LC-3b core memory port and line-wide physical memory.
module lc3b_cache
    import lc3b_types::*;
#(
    parameter int SETS       = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  lc3b_mem_wmask             mem_byte_enable,
    input  lc3b_word                  mem_address,
    input  lc3b_word                  mem_wdata,
    output lc3b_word                  mem_rdata,
    output logic                      mem_resp,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output lc3b_word                  pmem_address,
    output logic [8*LINE_BYTES-1:0]   pmem_wdata,
    input  logic [8*LINE_BYTES-1:0]   pmem_rdata,
    input  logic                      pmem_resp
);

    localparam int OFF  = $clog2(LINE_BYTES);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 16 - OFF - IDX;
    localparam int LW   = 8 * LINE_BYTES;

    typedef logic [TAGW-1:0] tag_t;
    typedef logic [IDX-1:0]  idx_t;
    typedef logic [LW-1:0]   line_t;

    logic [1:0]      r_valid [SETS];
    logic [1:0]      r_dirty [SETS];
    logic [SETS-1:0] r_lru;
    tag_t            r_tag   [2][SETS];
    line_t           r_data  [2][SETS];
    tag_t            r_req_tag;
    idx_t            r_req_idx;

    idx_t            w_idx;
    tag_t            w_tag;
    logic [OFF+2:0]  w_lo;
    logic [OFF+2:0]  w_hi;
    logic [1:0]      w_way_hit;
    logic            w_hit;
    logic            w_hit_way;
    logic            w_req;
    line_t           w_line;
    lc3b_cache_state w_state;
    logic            w_victim;
    logic            w_start;
    logic            w_hit_resp;
    logic            w_wb_done;
    logic            w_fill_done;

    assign w_idx = mem_address[OFF+IDX-1:OFF];
    assign w_tag = mem_address[15:OFF+IDX];
    // bit offsets of the addressed word's low and high bytes in a line
    assign w_lo  = {mem_address[OFF-1:0] & ~OFF'(1), 3'b000};
    assign w_hi  = w_lo | (OFF+3)'(8);
    assign w_req = mem_read | mem_write;

    assign w_way_hit[0] = r_valid[w_idx][0] && (r_tag[0][w_idx] == w_tag);
    assign w_way_hit[1] = r_valid[w_idx][1] && (r_tag[1][w_idx] == w_tag);
    assign w_hit        = |w_way_hit;
    assign w_hit_way    = w_way_hit[1];
    assign w_line       = r_data[w_hit_way][w_idx];

    cache_control u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_req        (w_req),
        .i_hit        (w_hit),
        .i_valid      (r_valid[w_idx]),
        .i_dirty      (r_dirty[w_idx]),
        .i_lru        (r_lru[w_idx]),
        .i_pmem_resp  (pmem_resp),
        .o_state      (w_state),
        .o_victim     (w_victim),
        .o_start      (w_start),
        .o_hit_resp   (w_hit_resp),
        .o_wb_done    (w_wb_done),
        .o_fill_done  (w_fill_done),
        .o_pmem_read  (pmem_read),
        .o_pmem_write (pmem_write)
    );

    assign mem_resp  = w_hit_resp;
    assign mem_rdata = w_hit_resp ? w_line[w_lo +: 16] : '0;

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        if (w_state == WRITEBACK) begin
            pmem_address = {r_tag[w_victim][r_req_idx], r_req_idx, {OFF{1'b0}}};
            pmem_wdata   = r_data[w_victim][r_req_idx];
        end else if (w_state == FILL) begin
            pmem_address = {r_req_tag, r_req_idx, {OFF{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= 2'b00;
                r_dirty[s] <= 2'b00;
            end
            r_lru     <= '0;
            r_req_tag <= '0;
            r_req_idx <= '0;
        end else begin
            if (w_hit_resp) begin
                r_lru[w_idx] <= ~w_hit_way;
                if (mem_write)
                    r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_start) begin
                r_req_tag <= w_tag;
                r_req_idx <= w_idx;
            end
            if (w_wb_done)
                r_dirty[r_req_idx][w_victim] <= 1'b0;
            if (w_fill_done) begin
                r_valid[r_req_idx][w_victim] <= 1'b1;
                r_dirty[r_req_idx][w_victim] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hit_resp && mem_write) begin
            if (mem_byte_enable[0])
                r_data[w_hit_way][w_idx][w_lo +: 8] <= mem_wdata[7:0];
            if (mem_byte_enable[1])
                r_data[w_hit_way][w_idx][w_hi +: 8] <= mem_wdata[15:8];
        end
        if (w_fill_done) begin
            r_data[w_victim][r_req_idx] <= pmem_rdata;
            r_tag[w_victim][r_req_idx]  <= r_req_tag;
        end
    end

endmodule

// File: tb/tb_lc3b_cache.sv
// Scoreboard bench for lc3b_cache: CPU responses and pmem transactions
// are checked against queues filled by the directed stimulus.
module tb_lc3b_cache;

    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [1:0]    mem_byte_enable = 2'b00;
    logic [15:0]   mem_address = 16'h0;
    logic [15:0]   mem_wdata = 16'h0;
    logic [15:0]   mem_rdata;
    logic          mem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int checks = 0;
    int errors = 0;
    int pm_lat = 0;

    typedef struct {
        bit          chk;
        logic [15:0] d;
    } resp_t;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        bit          chk;
        logic [15:0] w2;
    } ptx_t;

    resp_t         exp_q[$];
    ptx_t          pq[$];
    logic [LW-1:0] pm [logic [15:0]];

    lc3b_cache #(.SETS(8), .LINE_BYTES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] dflt(input logic [15:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < 8; k++)
            l[16*k +: 16] = 16'hA000 ^ (a + 16'(2*k));
        return l;
    endfunction

    // CPU response monitor
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (mem_resp) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected rdata=%h", mem_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk && mem_rdata !== e.d) begin
                        errors++;
                        $display("FAIL rdata got=%h exp=%h", mem_rdata, e.d);
                    end
                end
            end
        end
    end

    // physical memory model and pmem transaction monitor
    initial begin
        logic        wr;
        logic [15:0] ad;
        bit          abort;
        ptx_t        t;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!rst && (pmem_read || pmem_write)) begin
                wr = pmem_write;
                ad = pmem_address;
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pmem_unexpected wr=%0b addr=%h", wr, ad);
                end else begin
                    t = pq.pop_front();
                    if (t.wr != wr || t.a !== ad ||
                        (t.chk && pmem_wdata[47:32] !== t.w2)) begin
                        errors++;
                        $display("FAIL pmem_txn got wr=%0b a=%h w2=%h exp wr=%0b a=%h w2=%h",
                                 wr, ad, pmem_wdata[47:32], t.wr, t.a, t.w2);
                    end
                end
                checks++;
                if (pmem_read && pmem_write) begin
                    errors++;
                    $display("FAIL pmem_both rd=%0b wr=%0b exp one", pmem_read, pmem_write);
                end
                abort = 1'b0;
                for (int i = 0; i < pm_lat && !abort; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                    end else begin
                        checks++;
                        if (pmem_address !== ad || pmem_write !== wr || pmem_read !== !wr) begin
                            errors++;
                            $display("FAIL pmem_stable got a=%h rd=%0b wr=%0b exp a=%h wr=%0b",
                                     pmem_address, pmem_read, pmem_write, ad, wr);
                        end
                    end
                end
                if (!abort) begin
                    if (wr)
                        pm[ad] = pmem_wdata;
                    else
                        pmem_rdata = pm.exists(ad) ? pm[ad] : dflt(ad);
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    task automatic cpu(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [1:0] be, input logic [15:0] wd,
                       input bit chk, input logic [15:0] exp_d, input int exp_lat);
        int  n;
        bit  got;
        resp_t e;
        e.chk = chk;
        e.d   = exp_d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = a;
        mem_byte_enable = be;
        mem_wdata       = wd;
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            if (mem_resp) got = 1'b1;
            else n++;
        end
        checks++;
        if (!got) begin
            void'(exp_q.pop_back());
            errors++;
            $display("FAIL resp_timeout addr=%h waited=%0d exp_lat=%0d", a, n, exp_lat);
        end else if (n != exp_lat) begin
            errors++;
            $display("FAIL latency addr=%h got=%0d exp=%0d", a, n, exp_lat);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic exp_pmem(input bit wr, input logic [15:0] a,
                            input bit chk, input logic [15:0] w2);
        ptx_t t;
        t.wr  = wr;
        t.a   = a;
        t.chk = chk;
        t.w2  = w2;
        pq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    initial begin
        int n;
        pm[16'h0060] = 128'h1239_1238_1237_1236_1235_1234_1233_1232;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_resp", LW'(mem_resp), '0);
        chk("rst_mem_rdata", LW'(mem_rdata), '0);
        chk("rst_pmem_read", LW'(pmem_read), '0);
        chk("rst_pmem_write", LW'(pmem_write), '0);
        chk("rst_pmem_address", LW'(pmem_address), '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // cold miss then hits in the same line
        exp_pmem(0, 16'h0060, 0, 16'h0);
        cpu(1, 0, 16'h0064, 2'b00, 16'h0, 1, 16'h1234, 2);
        cpu(1, 0, 16'h0066, 2'b00, 16'h0, 1, 16'h1235, 0);

        // byte writes; read+write together behaves as a write
        cpu(0, 1, 16'h0064, 2'b10, 16'hAB00, 0, 16'h0, 0);
        cpu(1, 0, 16'h0064, 2'b00, 16'h0, 1, 16'hAB34, 0);
        cpu(1, 1, 16'h0066, 2'b01, 16'h00CD, 0, 16'h0, 0);
        cpu(1, 0, 16'h0066, 2'b00, 16'h0, 1, 16'h12CD, 0);

        // set 6 conflicts: clean eviction, then dirty eviction
        exp_pmem(0, 16'h00E0, 0, 16'h0);
        cpu(1, 0, 16'h00E0, 2'b00, 16'h0, 1, 16'hA0E0, 2);
        cpu(1, 0, 16'h0064, 2'b00, 16'h0, 1, 16'hAB34, 0);
        exp_pmem(0, 16'h0160, 0, 16'h0);
        cpu(1, 0, 16'h0160, 2'b00, 16'h0, 1, 16'hA160, 2);
        exp_pmem(1, 16'h0060, 1, 16'hAB34);
        exp_pmem(0, 16'h00E0, 0, 16'h0);
        cpu(1, 0, 16'h00E0, 2'b00, 16'h0, 1, 16'hA0E0, 3);

        // slow fill returns the line that was written back
        pm_lat = 10;
        exp_pmem(0, 16'h0060, 0, 16'h0);
        cpu(1, 0, 16'h0064, 2'b00, 16'h0, 1, 16'hAB34, 12);

        // reset in the middle of a fill
        pm_lat = 50;
        exp_pmem(0, 16'h0200, 0, 16'h0);
        @(posedge clk);
        #1;
        mem_read    = 1'b1;
        mem_address = 16'h0200;
        n = 0;
        while (n < 10 && !pmem_read) begin
            @(negedge clk);
            n++;
        end
        chk("fill_started", LW'(pmem_read), LW'(1));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_pmem_read", LW'(pmem_read), '0);
        chk("async_mem_resp", LW'(mem_resp), '0);
        chk("async_pmem_address", LW'(pmem_address), '0);
        mem_read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        pm_lat = 0;
        exp_pmem(0, 16'h0060, 0, 16'h0);
        cpu(1, 0, 16'h0064, 2'b00, 16'h0, 1, 16'hAB34, 2);
        exp_pmem(0, 16'h0200, 0, 16'h0);
        cpu(1, 0, 16'h0200, 2'b00, 16'h0, 1, 16'hA200, 2);

        repeat (3) @(posedge clk);
        chk("resp_q_drained", LW'(exp_q.size()), '0);
        chk("pmem_q_drained", LW'(pq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lc3b_cache.md
Name: lc3b_cache

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate cache between the LC-3b core's memory port and physical memory.
- The CPU side is a drop-in for the existing core memory interface: word address, 2-bit byte mask, hold-until-resp handshake.
- The memory side moves whole lines with its own read/write/resp handshake.
- Replacement is 1-bit LRU per set; a hit completes in the request cycle.

Parameters:
- SETS, 8, number of sets; power of two, >=2.
- LINE_BYTES, 16, bytes per line; power of two, 4..32; pmem data width = 8*LINE_BYTES.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  2  lc3b_mem_wmask; bit1 = high byte.
- mem_address  in  16  lc3b_word byte address; bit0 ignored.
- mem_wdata  in  16  lc3b_word write data.
- mem_rdata  out  16  read word.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_address  out  16  line-aligned address.
- pmem_wdata  out  8*LINE_BYTES  victim line.
- pmem_rdata  in  8*LINE_BYTES  fill line.
- pmem_resp  in  1  physical memory completion pulse.

Behaviour:
- Address split:
  - OFF = log2(LINE_BYTES); IDX = log2(SETS); TAG = 16-OFF-IDX.
  - Word select = addr[OFF-1:1].
- Per way per set: valid, dirty, tag, line data in flops, read asynchronously. Per set: lru bit (points at the way to evict).
- Reset:
  - Clears all valid, dirty and lru bits; state IDLE.
  - mem_resp, pmem_read and pmem_write go to 0 immediately.
  - mem_rdata, pmem_address and pmem_wdata reset to 0.
  - Data/tag arrays are not reset.
  - Reset mid-miss abandons the pmem transaction; no line is installed.
- FSM has three states: IDLE, WRITEBACK, FILL.
- IDLE:
  - No request: nothing happens.
  - Request and hit in way w:
    - mem_resp=1 combinationally in the same cycle.
    - Read: mem_rdata = selected word.
    - Write: merge mem_wdata into the selected word under mem_byte_enable at the clock edge; set dirty[w].
    - lru <= ~w.
  - Request and miss: pick a victim.
    - Victim is the first invalid way (way0 preferred), else the way given by lru.
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, OFF'b0}; pmem_wdata = victim line.
  - All held stable until pmem_resp.
  - On pmem_resp: clear the victim's dirty bit and go to FILL.
- FILL:
  - pmem_read=1; pmem_address = {req tag, index, OFF'b0}; held until pmem_resp.
  - On pmem_resp: write pmem_rdata into the victim way, set its tag, valid=1, dirty=0; go to IDLE.
  - The request then hits on the next cycle.
- Latency:
  - Hit: 0 cycles.
  - Clean miss: fill latency + 1.
  - Dirty miss: writeback latency + fill latency + 1.
- mem_resp is never asserted outside IDLE. pmem_read and pmem_write are never both 1.
- mem_read and mem_write both 1 is a protocol violation; the cache treats it as a write.
- A request dropped mid-miss still completes the fill; nothing is lost.
- pmem_resp arriving in IDLE is ignored.
- Every CPU address maps to exactly one set index; there is no wrap-around condition.

Decomposition:
- lc3b_types adds lc3b_cache_state (IDLE/WRITEBACK/FILL enum). lc3b_word and lc3b_mem_wmask are reused.
- Width-dependent types stay local to the module, derived from the parameters.
- Sub-module cache_control holds the FSM and victim/LRU decision. The arrays, tag compare and byte merge stay in lc3b_cache.

Test Plan (SETS=8, LINE_BYTES=16):
1. Cold read 0x0064, fill line with word2=0x1234:
   - One pmem_read at 0x0060, no pmem_write.
   - mem_resp with mem_rdata=0x1234 on the cycle after pmem_resp.
2. Read 0x0066 after case 1:
   - mem_resp in the request cycle.
   - pmem_read and pmem_write stay 0.
3. Write 0x0064, mask 2'b10, wdata 0xAB00:
   - mem_resp in the same cycle.
   - Readback of 0x0064 = 0xAB34.
4. Set 6 conflict, after case 3:
   - Read 0x00E0 (fill way1); read 0x0064 (hit).
   - Read 0x0160: evicts the 0x00E0 line; no pmem_write.
   - Read 0x00E0: pmem_write at 0x0060 with word2=0xAB34, then pmem_read at 0x00E0.
5. pmem_resp delayed 10 cycles:
   - pmem_read and pmem_address stable throughout.
   - mem_resp stays 0 until completion.
6. rst asserted mid-FILL:
   - pmem_read and mem_resp drop asynchronously.
   - After release, read 0x0064 misses again.
